// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and widths for the snake game flow controller
package game_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;
  localparam int LEVEL_W = 3;
endpackage

// File: rtl/game_flow_ctrl_btn_frame_edge.sv
// btn_frame_edge: synchronise an active-low button, sample it per frame and emit a one-cycle press
module btn_frame_edge (
  input  logic clk_pix,
  input  logic reset_n,
  input  logic frame_start,
  input  logic btn_n,
  output logic press
);
  logic s1, s2, prev;
  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
      if (frame_start) prev <= s2;
    end
  end
  assign press = frame_start & prev & ~s2;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: snake run/pause/over sequencer with level-scaled movement tick and restart pulse
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int BASE_DIV     = 5_000_000,
  parameter int DIV_DEC      = 500_000,
  parameter int MAX_LEVEL    = 7,
  parameter int LEVEL_EVERY  = 5,
  parameter int OVER_HOLD    = 60,
  parameter int BLINK_FRAMES = 30,
  parameter int DIV_W        = 23
) (
  input  logic               clk_pix,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic               start_n,
  input  logic               pause_n,
  input  logic               self_hit,
  input  logic               wall_hit,
  input  logic               eat_evt,
  output logic               tick_run,
  output logic               soft_rst,
  output logic               game_over,
  output logic               paused,
  output logic               idle,
  output logic               blink,
  output logic [LEVEL_W-1:0] level
);
  localparam int EAT_W   = $clog2(LEVEL_EVERY + 1);
  localparam int HOLD_W  = $clog2(OVER_HOLD + 1);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  state_t state, state_d;
  logic [DIV_W-1:0] div;
  logic [EAT_W-1:0] eat_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic start_p, pause_p, hit, eat_wrap, blink_wrap;
  function automatic logic [DIV_W-1:0] period(input logic [LEVEL_W-1:0] l);
    return DIV_W'(BASE_DIV - int'(l) * DIV_DEC - 1);
  endfunction
  btn_frame_edge u_start (
    .clk_pix(clk_pix),
    .reset_n(reset_n),
    .frame_start(frame_start),
    .btn_n(start_n),
    .press(start_p)
  );
  btn_frame_edge u_pause (
    .clk_pix(clk_pix),
    .reset_n(reset_n),
    .frame_start(frame_start),
    .btn_n(pause_n),
    .press(pause_p)
  );
  assign hit = self_hit | wall_hit;
  assign eat_wrap = eat_cnt == EAT_W'(LEVEL_EVERY - 1);
  assign blink_wrap = blink_cnt == BLINK_W'(BLINK_FRAMES - 1);
  always_ff @(posedge clk_pix) begin
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state;
    tick_run = 1'b0;
    soft_rst = 1'b0;
    case (state)
      IDLE: state_d = start_p ? ARM : IDLE;
      ARM: begin
        state_d = RUN;
        soft_rst = 1'b1;
      end
      RUN: begin
        state_d = hit ? OVER : pause_p ? PAUSE : RUN;
        tick_run = div == '0 && !hit;
      end
      PAUSE: state_d = pause_p ? RUN : PAUSE;
      OVER: state_d = start_p && hold_cnt == HOLD_W'(OVER_HOLD) ? ARM : OVER;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      div <= '0;
      level <= '0;
      eat_cnt <= '0;
      hold_cnt <= '0;
      blink_cnt <= '0;
      blink <= 1'b0;
      game_over <= 1'b0;
      paused <= 1'b0;
      idle <= 1'b1;
    end else begin
      game_over <= state_d == OVER;
      paused <= state_d == PAUSE;
      idle <= state_d == IDLE;
      if (state == ARM) begin
        div <= period('0);
        level <= '0;
        eat_cnt <= '0;
      end else if (state == RUN) begin
        if (state_d == RUN) div <= div == '0 ? period(level) : div - 1'b1;
        if (eat_evt) begin
          eat_cnt <= eat_wrap ? '0 : eat_cnt + 1'b1;
          if (eat_wrap && level != LEVEL_W'(MAX_LEVEL)) level <= level + 1'b1;
        end
      end
      hold_cnt <= state != OVER ? '0 : frame_start && hold_cnt != HOLD_W'(OVER_HOLD) ? hold_cnt + 1'b1 : hold_cnt;
      if (state == PAUSE || state == OVER) begin
        if (frame_start) begin
          blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
          if (blink_wrap) blink <= ~blink;
        end
      end else begin
        blink_cnt <= '0;
        blink <= 1'b0;
      end
    end
  end
endmodule
